// File: rtl/node_metadata_read_responder.sv
// AXI4-style read responder for per-node degree metadata; one beat per AR, valid the second edge after the AR handshake.
// Single outstanding read: arready is low until the R beat is taken, and the beat is held stable while rready is low.
module node_metadata_read_responder #(
  parameter int AXI_ADDR_WIDTH       = 32,
  parameter int AXI_DATA_WIDTH       = 64,
  parameter int NODE_METADATA_STRIDE = 8,
  parameter int MAX_NODES            = 1024,
  parameter int NODE_IDX_WIDTH       = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] graph_base_addr,
  input  logic [31:0]               num_nodes,
  input  logic                      load_en,
  input  logic [NODE_IDX_WIDTH-1:0] load_idx,
  input  logic [31:0]               load_degree,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [31:0]               rd_count,
  output logic [15:0]               err_count
);

  localparam int STRIDE_LSB = $clog2(NODE_METADATA_STRIDE);
  localparam int CW         = (AXI_ADDR_WIDTH > 32) ? AXI_ADDR_WIDTH : 32;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t                      state_q, state_d;
  logic [31:0]                 table_q [MAX_NODES];
  logic [NODE_IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                        err_q, err_d;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                  rresp_q, rresp_d;
  logic [31:0]                 rd_count_q, rd_count_d;
  logic [15:0]                 err_count_q, err_count_d;

  logic [AXI_ADDR_WIDTH-1:0]   offset;
  logic [CW-1:0]               idx_full;
  logic                        dec_err;
  logic                        ar_hs, r_hs;

  // Address decode against the base/limit presented in the handshake cycle.
  always_comb begin
    offset   = s_axi_araddr - graph_base_addr;
    idx_full = CW'(offset >> STRIDE_LSB);
    dec_err  = (s_axi_araddr < graph_base_addr)
            || (offset[STRIDE_LSB-1:0] != '0)
            || (idx_full >= CW'(num_nodes))
            || (idx_full >= CW'(MAX_NODES));
  end

  always_comb begin
    state_d       = state_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        s_axi_arready = rst_n;
        if (s_axi_arvalid && rst_n) state_d = LOOKUP;
      end
      LOOKUP: state_d = RESP;
      RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid && s_axi_rready;

  always_comb begin
    idx_d       = idx_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rd_count_d  = rd_count_q;
    err_count_d = err_count_q;
    if (ar_hs) begin
      idx_d = idx_full[NODE_IDX_WIDTH-1:0];
      err_d = dec_err;
    end
    // The table read happens on the LOOKUP edge, before any same-edge load lands.
    if (state_q == LOOKUP) begin
      rdata_d = err_q ? '0 : AXI_DATA_WIDTH'(table_q[idx_q]);
      rresp_d = err_q ? 2'b10 : 2'b00;
    end
    if (r_hs) begin
      rd_count_d = rd_count_q + 32'd1;
      if (err_q && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= 2'b00;
      rd_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rd_count_q  <= rd_count_d;
      err_count_q <= err_count_d;
    end
  end

  // Degree table survives rst_n; it is owned by the host load path.
  always_ff @(posedge clk) begin
    if (load_en) table_q[load_idx] <= load_degree;
  end

  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;
  assign rd_count    = rd_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_node_metadata_read_responder.sv
// Bench for node_metadata_read_responder: directed scenarios plus randomized reads against an address-rule model.
module tb_node_metadata_read_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] base = 32'h1000;
  logic [31:0] num = 32'd10;
  logic        load_en = 1'b0;
  logic [9:0]  load_idx = '0;
  logic [31:0] load_degree = '0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] rd_count;
  logic [15:0] err_count;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_deg [1024];
  int          m_rd = 0;
  int          m_err = 0;

  node_metadata_read_responder dut (
    .clk(clk), .rst_n(rst_n),
    .graph_base_addr(base), .num_nodes(num),
    .load_en(load_en), .load_idx(load_idx), .load_degree(load_degree),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .rd_count(rd_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected beat from the address rules alone.
  task automatic model_resp(input logic [31:0] addr, output logic [63:0] d, output logic [1:0] r, output bit e);
    longint off, idx;
    e = 1'b0;
    idx = 0;
    if (addr < base) e = 1'b1;
    else begin
      off = longint'(addr) - longint'(base);
      if (off % 8 != 0) e = 1'b1;
      else begin
        idx = off / 8;
        if (idx >= longint'(num) || idx >= 1024) e = 1'b1;
      end
    end
    d = e ? 64'd0 : {32'd0, model_deg[int'(idx)]};
    r = e ? 2'b10 : 2'b00;
  endtask

  task automatic load(input int idx, input logic [31:0] val);
    load_en = 1'b1; load_idx = 10'(idx); load_degree = val;
    tick;
    load_en = 1'b0;
    model_deg[idx] = val;
  endtask

  // Drives one AR, waits for the beat, takes it. lat = edges from AR handshake to rvalid (-1 on timeout).
  task automatic do_read(input logic [31:0] addr, output logic [63:0] d, output logic [1:0] r, output int lat);
    int w;
    araddr = addr; arvalid = 1'b1;
    w = 0;
    while (!arready && w < 20) begin tick; w++; end
    tick;
    arvalid = 1'b0;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      if (rvalid) begin lat = i; break; end
      tick;
    end
    d = rdata; r = rresp;
    rready = 1'b1;
    tick;
    rready = 1'b0;
  endtask

  task automatic test_reset;
    tick; tick;
    n_checks++; if (arready !== 1'b0) begin n_fail++; $display("FAIL reset_arready: got %0b want 0", arready); end
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %0b want 0", rvalid); end
    n_checks++; if (rdata !== 64'd0 || rresp !== 2'b00) begin n_fail++; $display("FAIL reset_rdata: got %0h/%0b want 0/0", rdata, rresp); end
    n_checks++; if (rd_count !== 32'd0 || err_count !== 16'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", rd_count, err_count); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (arready !== 1'b1) begin n_fail++; $display("FAIL release_arready: got %0b want 1", arready); end
  endtask

  task automatic test_ok_read;
    logic [63:0] d, ed; logic [1:0] r, er; bit e; int lat;
    load(3, 32'd42);
    base = 32'h1000; num = 32'd10;
    model_resp(32'h1018, ed, er, e);
    do_read(32'h1018, d, r, lat);
    m_rd++; if (e) m_err++;
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ok_latency: got %0d want 1", lat); end
    n_checks++; if (d !== ed || ed !== 64'd42) begin n_fail++; $display("FAIL ok_rdata: got %0h want %0h", d, ed); end
    n_checks++; if (r !== er) begin n_fail++; $display("FAIL ok_rresp: got %0b want %0b", r, er); end
    n_checks++; if (rd_count !== 32'(m_rd)) begin n_fail++; $display("FAIL ok_rd_count: got %0d want %0d", rd_count, m_rd); end
    n_checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin n_fail++; $display("FAIL ok_after_hs: got rvalid=%0b arready=%0b want 0/1", rvalid, arready); end
  endtask

  task automatic test_errors;
    logic [31:0] addrs [3] = '{32'h1050, 32'h1004, 32'h0FF8};
    logic [63:0] d, ed; logic [1:0] r, er; bit e; int lat;
    for (int i = 0; i < 3; i++) begin
      model_resp(addrs[i], ed, er, e);
      do_read(addrs[i], d, r, lat);
      m_rd++; if (e) m_err++;
      n_checks++; if (r !== 2'b10 || r !== er) begin n_fail++; $display("FAIL err_rresp[%0h]: got %0b want 10", addrs[i], r); end
      n_checks++; if (d !== 64'd0) begin n_fail++; $display("FAIL err_rdata[%0h]: got %0h want 0", addrs[i], d); end
      n_checks++; if (err_count !== 16'(m_err)) begin n_fail++; $display("FAIL err_count[%0h]: got %0d want %0d", addrs[i], err_count, m_err); end
    end
    n_checks++; if (rd_count !== 32'(m_rd)) begin n_fail++; $display("FAIL err_rd_count: got %0d want %0d", rd_count, m_rd); end
  endtask

  task automatic test_boundary;
    logic [31:0] addrs [3];
    logic [31:0] nums [3] = '{32'd2000, 32'd2000, 32'd0};
    logic [63:0] d, ed; logic [1:0] r, er; bit e; int lat;
    load(1023, 32'hDEADBEEF);
    base = 32'h0004_0000;
    addrs[0] = base + 32'd1023 * 8;
    addrs[1] = base + 32'd1024 * 8;
    addrs[2] = base;
    for (int i = 0; i < 3; i++) begin
      num = nums[i];
      model_resp(addrs[i], ed, er, e);
      do_read(addrs[i], d, r, lat);
      m_rd++; if (e) m_err++;
      n_checks++; if (d !== ed || r !== er) begin n_fail++; $display("FAIL boundary[%0d]: got %0h/%0b want %0h/%0b", i, d, r, ed, er); end
    end
    n_checks++; if (err_count !== 16'(m_err)) begin n_fail++; $display("FAIL boundary_err_count: got %0d want %0d", err_count, m_err); end
    base = 32'h1000; num = 32'd10;
  endtask

  task automatic test_backpressure;
    logic [63:0] held;
    load(2, 32'h55);
    araddr = base + 32'd16; arvalid = 1'b1;
    tick;
    araddr = base + 32'd24;
    tick;
    held = rdata;
    n_checks++; if (held !== 64'h55) begin n_fail++; $display("FAIL bp_rdata: got %0h want 55", held); end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== 64'h55 || rresp !== 2'b00 || arready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got rvalid=%0b rdata=%0h rresp=%0b arready=%0b want 1/55/0/0", i, rvalid, rdata, rresp, arready);
      end
      tick;
    end
    arvalid = 1'b0; rready = 1'b1;
    tick;
    rready = 1'b0;
    m_rd++;
    n_checks++; if (rvalid !== 1'b0 || rd_count !== 32'(m_rd)) begin n_fail++; $display("FAIL bp_release: got rvalid=%0b rd_count=%0d want 0/%0d", rvalid, rd_count, m_rd); end
    tick; tick; tick;
    n_checks++; if (rvalid !== 1'b0 || rd_count !== 32'(m_rd)) begin n_fail++; $display("FAIL bp_single: got rvalid=%0b rd_count=%0d want 0/%0d", rvalid, rd_count, m_rd); end
  endtask

  task automatic test_back_to_back;
    int n_acc, n_rsp;
    int rsp_cyc [4];
    logic [63:0] got [4];
    bit acc, rs;
    for (int i = 0; i < 4; i++) load(i, 32'(i + 1));
    n_acc = 0; n_rsp = 0;
    araddr = base; arvalid = 1'b1; rready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc = arvalid && arready;
      rs = rvalid && rready;
      if (rs && n_rsp < 4) begin got[n_rsp] = rdata; rsp_cyc[n_rsp] = cyc; n_rsp++; end
      tick;
      if (acc) begin
        n_acc++;
        if (n_acc == 4) arvalid = 1'b0;
        else araddr = base + 32'(n_acc * 8);
      end
    end
    rready = 1'b0;
    m_rd += 4;
    n_checks++; if (n_rsp !== 4 || n_acc !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d rsp %0d acc want 4/4", n_rsp, n_acc); end
    for (int i = 0; i < 4 && i < n_rsp; i++) begin
      n_checks++; if (got[i] !== {32'd0, model_deg[i]}) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0h want %0h", i, got[i], model_deg[i]); end
      if (i > 0) begin
        n_checks++; if (rsp_cyc[i] - rsp_cyc[i-1] !== 3) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", i, rsp_cyc[i] - rsp_cyc[i-1]); end
      end
    end
    n_checks++; if (rd_count !== 32'(m_rd)) begin n_fail++; $display("FAIL b2b_rd_count: got %0d want %0d", rd_count, m_rd); end
  endtask

  task automatic test_read_before_write;
    logic [63:0] d, ed; logic [1:0] r, er; bit e; int lat;
    load(5, 32'd7);
    araddr = base + 32'd40; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    load_en = 1'b1; load_idx = 10'd5; load_degree = 32'd9;
    tick;
    load_en = 1'b0;
    model_deg[5] = 32'd9;
    n_checks++; if (rvalid !== 1'b1 || rdata !== 64'd7) begin n_fail++; $display("FAIL rbw_old: got rvalid=%0b rdata=%0h want 1/7", rvalid, rdata); end
    rready = 1'b1; tick; rready = 1'b0;
    m_rd++;
    model_resp(base + 32'd40, ed, er, e);
    do_read(base + 32'd40, d, r, lat);
    m_rd++; if (e) m_err++;
    n_checks++; if (d !== ed || ed !== 64'd9) begin n_fail++; $display("FAIL rbw_new: got %0h want %0h", d, ed); end
  endtask

  task automatic test_random;
    logic [63:0] d, ed; logic [1:0] r, er; bit e; int lat, idx, mode;
    logic [31:0] addr;
    for (int i = 0; i < 32; i++) load(i, $urandom);
    for (int it = 0; it < 40; it++) begin
      base = {12'h0, 8'($urandom_range(1, 255)), 12'h0};
      num = 32'($urandom_range(0, 32));
      idx = $urandom_range(0, 40);
      mode = $urandom_range(0, 7);
      if (mode == 0) addr = base - 32'($urandom_range(1, 4) * 8);
      else if (mode == 1) addr = base + 32'(idx * 8 + $urandom_range(1, 7));
      else addr = base + 32'(idx * 8);
      if ($urandom_range(0, 3) == 0) load($urandom_range(0, 31), $urandom);
      model_resp(addr, ed, er, e);
      do_read(addr, d, r, lat);
      m_rd++; if (e) m_err++;
      n_checks++;
      if (d !== ed || r !== er || lat !== 1) begin
        n_fail++;
        $display("FAIL rand[%0d] addr=%0h base=%0h num=%0d: got %0h/%0b lat %0d want %0h/%0b lat 1", it, addr, base, num, d, r, lat, ed, er);
      end
    end
    n_checks++; if (rd_count !== 32'(m_rd) || err_count !== 16'(m_err)) begin n_fail++; $display("FAIL rand_counts: got %0d/%0d want %0d/%0d", rd_count, err_count, m_rd, m_err); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] d, ed; logic [1:0] r, er; bit e; int lat;
    base = 32'h1000; num = 32'd10;
    araddr = base + 32'd24; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    tick;
    n_checks++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL mid_in_resp: got rvalid=%0b want 1", rvalid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (rvalid !== 1'b0 || arready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_outputs: got rvalid=%0b arready=%0b want 0/0", rvalid, arready); end
    n_checks++; if (rd_count !== 32'd0 || err_count !== 16'd0) begin n_fail++; $display("FAIL mid_reset_counts: got %0d/%0d want 0/0", rd_count, err_count); end
    m_rd = 0; m_err = 0;
    tick;
    rst_n = 1'b1;
    #1;
    n_checks++; if (arready !== 1'b1) begin n_fail++; $display("FAIL mid_release_arready: got %0b want 1", arready); end
    model_resp(base + 32'd24, ed, er, e);
    do_read(base + 32'd24, d, r, lat);
    m_rd++; if (e) m_err++;
    n_checks++; if (d !== ed || r !== 2'b00) begin n_fail++; $display("FAIL mid_retained: got %0h/%0b want %0h/0", d, r, ed); end
    n_checks++; if (rd_count !== 32'(m_rd)) begin n_fail++; $display("FAIL mid_rd_count: got %0d want %0d", rd_count, m_rd); end
  endtask

  initial begin
    test_reset;
    test_ok_read;
    test_errors;
    test_boundary;
    test_backpressure;
    test_back_to_back;
    test_read_before_write;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
